// File: rtl/mp_cache_data_ctrl_pkg.sv
// Shared types and sizing for the cache data-array controller.
// Every width is derived from the array geometry below.
package mp_cache_data_pkg;
  localparam int NUM_SETS    = 16;
  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int NUM_BEATS   = LINE_WIDTH / BURST_WIDTH;
  localparam int WMASK_WIDTH = LINE_WIDTH / 8;
  localparam int SET_WIDTH   = $clog2(NUM_SETS);
  localparam int BEAT_WIDTH  = $clog2(NUM_BEATS);
  localparam int LBIT_WIDTH  = $clog2(LINE_WIDTH);
  localparam int BBIT_WIDTH  = $clog2(BURST_WIDTH);

  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_WB    = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_RSP,
    ST_FILL,
    ST_FILL_WR,
    ST_WB_CAP,
    ST_WB_SEND
  } state_t;
endpackage

// File: rtl/mp_cache_data_ctrl_if.sv
// Bundle of the cache-FSM request/response, memory burst and data-array ports.
// The slave modport is the controller; the master modport is its surroundings.
interface mp_cache_data_ctrl_if;
  logic                                       req_valid;
  logic                                       req_ready;
  logic [1:0]                                 req_op;
  logic [mp_cache_data_pkg::SET_WIDTH-1:0]    req_set;
  logic [mp_cache_data_pkg::WMASK_WIDTH-1:0]  req_wmask;
  logic [mp_cache_data_pkg::LINE_WIDTH-1:0]   req_wdata;
  logic                                       rsp_valid;
  logic [mp_cache_data_pkg::LINE_WIDTH-1:0]   rsp_rdata;
  logic                                       xfer_done;
  logic                                       mem_rvalid;
  logic [mp_cache_data_pkg::BURST_WIDTH-1:0]  mem_rdata;
  logic                                       mem_wvalid;
  logic                                       mem_wready;
  logic [mp_cache_data_pkg::BURST_WIDTH-1:0]  mem_wdata;
  logic                                       sram_csb0;
  logic                                       sram_web0;
  logic [mp_cache_data_pkg::WMASK_WIDTH-1:0]  sram_wmask0;
  logic [mp_cache_data_pkg::SET_WIDTH-1:0]    sram_addr0;
  logic [mp_cache_data_pkg::LINE_WIDTH-1:0]   sram_din0;
  logic [mp_cache_data_pkg::LINE_WIDTH-1:0]   sram_dout0;

  modport slave (
    input  req_valid, req_op, req_set, req_wmask, req_wdata,
    input  mem_rvalid, mem_rdata, mem_wready, sram_dout0,
    output req_ready, rsp_valid, rsp_rdata, xfer_done,
    output mem_wvalid, mem_wdata,
    output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0
  );

  modport master (
    output req_valid, req_op, req_set, req_wmask, req_wdata,
    output mem_rvalid, mem_rdata, mem_wready, sram_dout0,
    input  req_ready, rsp_valid, rsp_rdata, xfer_done,
    input  mem_wvalid, mem_wdata,
    input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0
  );
endinterface

// File: rtl/mp_cache_line_buf.sv
// Line buffer shared by fill (beat-indexed load) and writeback (parallel load, then
// shift out low beat first), with the beat counter that sequences both.
module mp_cache_line_buf
  import mp_cache_data_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_beat_load,
  input  logic [BURST_WIDTH-1:0] i_beat_data,
  input  logic                   i_par_load,
  input  logic [LINE_WIDTH-1:0]  i_par_data,
  input  logic                   i_shift,
  output logic [LINE_WIDTH-1:0]  o_line,
  output logic [BEAT_WIDTH-1:0]  o_beat_cnt
);
  logic [LINE_WIDTH-1:0] r_line;
  logic [BEAT_WIDTH-1:0] r_cnt;
  logic [LBIT_WIDTH-1:0] w_base;

  assign w_base = {r_cnt, {BBIT_WIDTH{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_clr)
        r_cnt <= '0;
      else if (i_beat_load || i_shift)
        r_cnt <= r_cnt + 1'b1;

      if (i_par_load)
        r_line <= i_par_data;
      else if (i_beat_load)
        r_line[w_base +: BURST_WIDTH] <= i_beat_data;
      else if (i_shift)
        r_line <= r_line >> BURST_WIDTH;
    end
  end

  assign o_line     = r_line;
  assign o_beat_cnt = r_cnt;
endmodule

// File: rtl/mp_cache_data_ctrl.sv
// Data-array controller: hit reads/writes go straight to the array from IDLE;
// fills and writebacks stage a whole line through mp_cache_line_buf.
//
//   state      | meaning
//   IDLE       | accepting requests; reads/writes drive the array directly
//   RD_RSP     | array read data returned on rsp_rdata
//   FILL       | collecting memory beats into the line buffer
//   FILL_WR    | full-line array write of the assembled fill, response pulse
//   WB_CAP     | array read data captured into the line buffer
//   WB_SEND    | streaming the line out to memory, low beat first
module mp_cache_data_ctrl
  import mp_cache_data_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mp_cache_data_ctrl_if.slave bus
);
  state_t                 r_state;
  logic [SET_WIDTH-1:0]   r_set;
  logic                   r_ready_en;

  logic                   w_accept;
  op_t                    w_op;
  logic                   w_fill_beat;
  logic                   w_wb_hs;
  logic                   w_last;
  logic [LINE_WIDTH-1:0]  w_line;
  logic [BEAT_WIDTH-1:0]  w_beat_cnt;

  assign w_op        = op_t'(bus.req_op);
  assign w_accept    = bus.req_valid && bus.req_ready;
  assign w_fill_beat = (r_state == ST_FILL) && bus.mem_rvalid;
  assign w_wb_hs     = (r_state == ST_WB_SEND) && bus.mem_wready;
  assign w_last      = (w_beat_cnt == LAST_BEAT);

  mp_cache_line_buf u_line_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_accept && (w_op == OP_FILL || w_op == OP_WB)),
    .i_beat_load (w_fill_beat),
    .i_beat_data (bus.mem_rdata),
    .i_par_load  (r_state == ST_WB_CAP),
    .i_par_data  (bus.sram_dout0),
    .i_shift     (w_wb_hs),
    .o_line      (w_line),
    .o_beat_cnt  (w_beat_cnt)
  );

  // r_ready_en keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_set      <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_set <= bus.req_set;
            case (w_op)
              OP_READ:  r_state <= ST_RD_RSP;
              OP_FILL:  r_state <= ST_FILL;
              OP_WB:    r_state <= ST_WB_CAP;
              default:  r_state <= ST_IDLE;
            endcase
          end
        end
        ST_RD_RSP:  r_state <= ST_IDLE;
        ST_FILL:    if (w_fill_beat && w_last) r_state <= ST_FILL_WR;
        ST_FILL_WR: r_state <= ST_IDLE;
        ST_WB_CAP:  r_state <= ST_WB_SEND;
        ST_WB_SEND: if (w_wb_hs && w_last) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_ready_en && (r_state == ST_IDLE);

  always_comb begin
    bus.sram_csb0   = 1'b1;
    bus.sram_web0   = 1'b1;
    bus.sram_wmask0 = '0;
    bus.sram_addr0  = '0;
    bus.sram_din0   = '0;
    if (r_state == ST_IDLE && w_accept) begin
      bus.sram_csb0  = 1'b0;
      bus.sram_addr0 = bus.req_set;
      if (w_op == OP_WRITE) begin
        bus.sram_web0   = 1'b0;
        bus.sram_wmask0 = bus.req_wmask;
        bus.sram_din0   = bus.req_wdata;
      end
    end else if (r_state == ST_FILL_WR) begin
      bus.sram_csb0   = 1'b0;
      bus.sram_web0   = 1'b0;
      bus.sram_wmask0 = '1;
      bus.sram_addr0  = r_set;
      bus.sram_din0   = w_line;
    end
  end

  always_comb begin
    bus.rsp_rdata = '0;
    if (r_state == ST_RD_RSP)
      bus.rsp_rdata = bus.sram_dout0;
    else if (r_state == ST_FILL_WR)
      bus.rsp_rdata = w_line;
  end

  assign bus.rsp_valid  = (r_state == ST_RD_RSP) || (r_state == ST_FILL_WR);
  assign bus.mem_wvalid = (r_state == ST_WB_SEND);
  assign bus.mem_wdata  = (r_state == ST_WB_SEND) ? w_line[BURST_WIDTH-1:0] : '0;
  assign bus.xfer_done  = w_wb_hs && w_last;
endmodule

// File: tb/tb_mp_cache_data_ctrl.sv
// Directed bench for mp_cache_data_ctrl with a behavioural byte-masked array model.
module tb_mp_cache_data_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mp_cache_data_ctrl_if bus ();

  mp_cache_data_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Array model: samples on the rising edge, read data valid the next cycle.
  logic [255:0] arr [16];
  logic [255:0] arr_dout = '0;
  assign bus.sram_dout0 = arr_dout;

  always @(posedge clk) begin
    if (!bus.sram_csb0) begin
      if (!bus.sram_web0) begin
        for (int b = 0; b < 32; b++)
          if (bus.sram_wmask0[b]) arr[bus.sram_addr0][8*b +: 8] <= bus.sram_din0[8*b +: 8];
      end else begin
        arr_dout <= arr[bus.sram_addr0];
      end
    end
  end

  localparam logic [255:0] FILL9 = {64'h3333333333333333, 64'h2222222222222222,
                                    64'h1111111111111111, 64'h0000000000000000};
  logic [63:0] wb_beats [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [3:0] set,
                        input logic [31:0] mask, input logic [255:0] data);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_set   = set;
    bus.req_wmask = mask;
    bus.req_wdata = data;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_set = '0;
    bus.req_wmask = '0; bus.req_wdata = '0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_wready = 1'b0;
    rst_n = 1'b0;
    step(); step();
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL rst_req_ready got %b want 0", bus.req_ready); else n_pass++;
    n_checks++;
    if ({bus.sram_csb0, bus.sram_web0, bus.sram_wmask0, bus.sram_addr0} !== {1'b1, 1'b1, 32'h0, 4'h0})
      $display("FAIL rst_sram_ctl got csb=%b web=%b wm=%h a=%h", bus.sram_csb0, bus.sram_web0, bus.sram_wmask0, bus.sram_addr0);
    else n_pass++;
    n_checks++; if (bus.sram_din0 !== '0) $display("FAIL rst_din got %h want 0", bus.sram_din0); else n_pass++;
    n_checks++;
    if ({bus.rsp_valid, bus.xfer_done, bus.mem_wvalid} !== 3'b000 || bus.mem_wdata !== '0 || bus.rsp_rdata !== '0)
      $display("FAIL rst_outs got rv=%b xd=%b wv=%b wd=%h rd=%h", bus.rsp_valid, bus.xfer_done, bus.mem_wvalid, bus.mem_wdata, bus.rsp_rdata);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rel_req_ready got %b want 1", bus.req_ready); else n_pass++;
  endtask

  task automatic test_masked_write();
    bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_set = 4'd3;
    bus.req_wmask = 32'hFFFFFFFF; bus.req_wdata = {32{8'hAA}};
    #1;
    n_checks++;
    if ({bus.sram_csb0, bus.sram_web0, bus.sram_addr0, bus.sram_wmask0} !== {1'b0, 1'b0, 4'd3, 32'hFFFFFFFF})
      $display("FAIL wr_sram_ctl got csb=%b web=%b a=%h wm=%h", bus.sram_csb0, bus.sram_web0, bus.sram_addr0, bus.sram_wmask0);
    else n_pass++;
    step();
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
      $display("FAIL wr_no_rsp got ready=%b rv=%b want 1 0", bus.req_ready, bus.rsp_valid);
    else n_pass++;
    do_req(2'b01, 4'd3, 32'h00000001, {32{8'h55}});
    do_req(2'b00, 4'd3, 32'h0, '0);
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid got %b want 1", bus.rsp_valid); else n_pass++;
    n_checks++;
    if (bus.rsp_rdata !== {{31{8'hAA}}, 8'h55}) $display("FAIL rd_masked got %h want %h", bus.rsp_rdata, {{31{8'hAA}}, 8'h55});
    else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL rd_rsp_ready got %b want 0", bus.req_ready); else n_pass++;
    step();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL rd_pulse_end got rv=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [255:0] d5;
    d5 = {8{32'hDEAD0005}};
    do_req(2'b01, 4'd5, 32'hFFFFFFFF, d5);
    do_req(2'b00, 4'd5, 32'h0, '0);
    n_checks++; if (bus.rsp_rdata !== d5 || bus.rsp_valid !== 1'b1)
      $display("FAIL wr_rd_hazard got %h rv=%b want %h", bus.rsp_rdata, bus.rsp_valid, d5);
    else n_pass++;
    step();
  endtask

  task automatic test_fill();
    do_req(2'b10, 4'd9, 32'h0, '0);
    for (int i = 0; i < 4; i++) begin
      step(); step();
      n_checks++; if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0)
        $display("FAIL fill_busy beat %0d got ready=%b rv=%b want 0 0", i, bus.req_ready, bus.rsp_valid);
      else n_pass++;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 64'h1111111111111111 * i;
      step();
      bus.mem_rvalid = 1'b0;
    end
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== FILL9)
      $display("FAIL fill_rsp got rv=%b %h want 1 %h", bus.rsp_valid, bus.rsp_rdata, FILL9);
    else n_pass++;
    n_checks++;
    if ({bus.sram_csb0, bus.sram_web0, bus.sram_addr0, bus.sram_wmask0} !== {1'b0, 1'b0, 4'd9, 32'hFFFFFFFF} || bus.sram_din0 !== FILL9)
      $display("FAIL fill_wr got csb=%b web=%b a=%h wm=%h din=%h", bus.sram_csb0, bus.sram_web0, bus.sram_addr0, bus.sram_wmask0, bus.sram_din0);
    else n_pass++;
    step();
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL fill_end got rv=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
    else n_pass++;
    do_req(2'b00, 4'd9, 32'h0, '0);
    n_checks++; if (bus.rsp_rdata !== FILL9) $display("FAIL fill_readback got %h want %h", bus.rsp_rdata, FILL9); else n_pass++;
    step();
  endtask

  task automatic test_writeback();
    wb_beats[0] = 64'h0123456789ABCDEF;
    wb_beats[1] = 64'hFEDCBA9876543210;
    wb_beats[2] = 64'hA5A5A5A55A5A5A5A;
    wb_beats[3] = 64'hDEADBEEFCAFEF00D;
    do_req(2'b01, 4'd2, 32'hFFFFFFFF, {wb_beats[3], wb_beats[2], wb_beats[1], wb_beats[0]});
    bus.mem_wready = 1'b0;
    do_req(2'b11, 4'd2, 32'h0, '0);
    n_checks++; if (bus.mem_wvalid !== 1'b0 || bus.req_ready !== 1'b0)
      $display("FAIL wb_cap got wv=%b ready=%b want 0 0", bus.mem_wvalid, bus.req_ready);
    else n_pass++;
    step();
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.mem_wvalid !== 1'b1 || bus.mem_wdata !== wb_beats[k])
        $display("FAIL wb_beat%0d got wv=%b %h want 1 %h", k, bus.mem_wvalid, bus.mem_wdata, wb_beats[k]);
      else n_pass++;
      step();
      n_checks++;
      if (bus.mem_wvalid !== 1'b1 || bus.mem_wdata !== wb_beats[k] || bus.req_ready !== 1'b0 || bus.xfer_done !== 1'b0)
        $display("FAIL wb_stall%0d got wv=%b %h ready=%b xd=%b want 1 %h 0 0", k, bus.mem_wvalid, bus.mem_wdata, bus.req_ready, bus.xfer_done, wb_beats[k]);
      else n_pass++;
      bus.mem_wready = 1'b1;
      #1;
      n_checks++; if (bus.xfer_done !== (k == 3))
        $display("FAIL wb_xfer_done%0d got %b want %b", k, bus.xfer_done, (k == 3));
      else n_pass++;
      #1;
      @(posedge clk); #1;
      bus.mem_wready = 1'b0;
    end
    n_checks++; if (bus.mem_wvalid !== 1'b0 || bus.req_ready !== 1'b1 || bus.xfer_done !== 1'b0)
      $display("FAIL wb_end got wv=%b ready=%b xd=%b want 0 1 0", bus.mem_wvalid, bus.req_ready, bus.xfer_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    do_req(2'b10, 4'd9, 32'h0, '0);
    for (int i = 0; i < 2; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 64'hEEEEEEEEEEEEEEEE;
      step();
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0 || bus.sram_csb0 !== 1'b1 || bus.sram_web0 !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0)
      $display("FAIL midfill_rst got ready=%b csb=%b web=%b rv=%b rd=%h", bus.req_ready, bus.sram_csb0, bus.sram_web0, bus.rsp_valid, bus.rsp_rdata);
    else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.sram_csb0 !== 1'b1 || bus.rsp_valid !== 1'b0)
        $display("FAIL stray_beat%0d got csb=%b rv=%b want 1 0", i, bus.sram_csb0, bus.rsp_valid);
      else n_pass++;
      step();
    end
    bus.mem_rvalid = 1'b0;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL midfill_ready got %b want 1", bus.req_ready); else n_pass++;
    do_req(2'b00, 4'd9, 32'h0, '0);
    n_checks++; if (bus.rsp_rdata !== FILL9) $display("FAIL midfill_old got %h want %h", bus.rsp_rdata, FILL9); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_back_to_back();
    test_fill();
    test_writeback();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
